// File: rtl/cnt_mon_pkg.sv
// Shared constants and helpers for the monitored activity counter.
package cnt_mon_pkg;

  // All-ones of width w (w <= 64), callers cast down to their own width.
  function automatic logic [63:0] sat_max(input int w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  // Terminal value: all-ones counting up, zero counting down.
  function automatic logic [63:0] term(input logic up, input int width);
    return up ? sat_max(width) : 64'd0;
  endfunction

endpackage

// File: rtl/cnt_mon_core.sv
// Up/down counter with clear > load > enable priority, wrap or saturate at the terminal value, registered tc.
// ovr replaces the computed next value; the shadow copy uses it for resync and fault injection.
module cnt_core
  import cnt_mon_pkg::*;
#(
  parameter int WIDTH = 28,
  parameter int WRAP  = 1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovr,
  input  logic [WIDTH-1:0] ovr_val,
  output logic [WIDTH-1:0] nxt,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);
  localparam bit WRAP_EN = (WRAP != 0);

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] stepped;
  logic             at_t;
  logic             adv;
  logic             tc_ev;

  assign t       = WIDTH'(term(up, WIDTH));
  assign at_t    = (cnt == t);
  assign stepped = up ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
  assign adv     = en && !clr && !load;
  // Wrapping counters pulse on leaving T; saturating ones pulse on arriving at T.
  assign tc_ev   = adv && (WRAP_EN ? at_t : (!at_t && (stepped == t)));

  always_comb begin
    nxt = cnt;
    if (clr)                            nxt = '0;
    else if (load)                      nxt = load_val;
    else if (adv && (WRAP_EN || !at_t)) nxt = stepped;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt <= '0;
      tc  <= 1'b0;
    end else begin
      cnt <= ovr ? ovr_val : nxt;
      tc  <= tc_ev;
    end
  end
endmodule

// File: rtl/cnt_mon.sv
// Activity counter with a duplicated shadow copy; divergence is flagged, counted and resynchronised.
module cnt_mon
  import cnt_mon_pkg::*;
#(
  parameter int WIDTH = 28,
  parameter int OUT_W = 4,
  parameter int ERR_W = 8,
  parameter int WRAP  = 1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inj,
  input  logic             err_clr,
  output logic [OUT_W-1:0] cntout,
  output logic [WIDTH-1:0] cnt_full,
  output logic             tc,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt
);
  localparam logic [ERR_W-1:0] ERR_SAT = ERR_W'(sat_max(ERR_W));

  logic [WIDTH-1:0] a, b, nxt_a, nxt_b, b_ovr_val;
  logic             detect, b_ovr, mm_pend;
  logic             unused_tc_b;

  assign detect    = (a != b);
  assign b_ovr     = detect || inj;
  // Resync takes precedence, so an injection landing on a resync cycle is dropped.
  assign b_ovr_val = detect ? nxt_a : (nxt_b ^ WIDTH'(1));

  cnt_core #(.WIDTH(WIDTH), .WRAP(WRAP)) u_a (
    .clk(clk), .nreset(nreset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .ovr(1'b0), .ovr_val(nxt_a), .nxt(nxt_a), .cnt(a), .tc(tc)
  );

  cnt_core #(.WIDTH(WIDTH), .WRAP(WRAP)) u_b (
    .clk(clk), .nreset(nreset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .ovr(b_ovr), .ovr_val(b_ovr_val), .nxt(nxt_b), .cnt(b),
    .tc(unused_tc_b)
  );

  assign cnt_full = a;
  assign cntout   = a[WIDTH-1 -: OUT_W];

  // A detection coinciding with err_clr still counts, but the flag is only raised a cycle later.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mismatch <= 1'b0;
      err_cnt  <= '0;
      mm_pend  <= 1'b0;
    end else begin
      mm_pend <= detect && err_clr;
      if (err_clr)                  mismatch <= 1'b0;
      else if (detect || mm_pend)   mismatch <= 1'b1;
      if (err_clr)                  err_cnt  <= detect ? ERR_W'(1) : '0;
      else if (detect && (err_cnt != ERR_SAT)) err_cnt <= err_cnt + ERR_W'(1);
    end
  end
endmodule

// File: tb/tb_cnt_mon.sv
// Scoreboard bench: wrapping and saturating instances share stimulus; a reference model queues expectations.
module tb_cnt_mon;
  localparam int W       = 8;
  localparam int MOD     = 1 << W;
  localparam int MAXV    = MOD - 1;
  localparam int ERR_MAX = 3;

  logic         clk, nreset, en, up, clr, load, inj, err_clr;
  logic [W-1:0] load_val;
  logic [3:0]   cntout_w, cntout_s;
  logic [W-1:0] cnt_w, cnt_s;
  logic         tc_w, tc_s, mm_w, mm_s;
  logic [1:0]   err_w, err_s;

  cnt_mon #(.WIDTH(W), .OUT_W(4), .ERR_W(2), .WRAP(1)) u_wrap (
    .clk(clk), .nreset(nreset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .inj(inj), .err_clr(err_clr), .cntout(cntout_w),
    .cnt_full(cnt_w), .tc(tc_w), .mismatch(mm_w), .err_cnt(err_w)
  );

  cnt_mon #(.WIDTH(W), .OUT_W(4), .ERR_W(2), .WRAP(0)) u_sat (
    .clk(clk), .nreset(nreset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .inj(inj), .err_clr(err_clr), .cntout(cntout_s),
    .cnt_full(cnt_s), .tc(tc_s), .mismatch(mm_s), .err_cnt(err_s)
  );

  typedef struct {
    int cnt;
    bit tc;
    bit mm;
    int err;
  } exp_t;

  exp_t q_w[$];
  exp_t q_s[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model state: index 0 = wrapping instance, 1 = saturating instance.
  int m_cnt[2];
  bit m_tc[2];
  bit m_ups[2];   // shadow currently diverged from primary
  bit m_mm[2];
  bit m_pend[2];
  int m_err[2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_tc[k] = 0; m_ups[k] = 0;
      m_mm[k] = 0; m_pend[k] = 0; m_err[k] = 0;
    end
  endtask

  task automatic model_step(int k, bit wr, bit e, bit u, bit c, bit l, int lv, bit i, bit ec);
    int t, d, nc;
    bit tcn, ups;
    t   = u ? MAXV : 0;
    d   = u ? 1 : MAXV;
    nc  = m_cnt[k];
    tcn = 0;
    if (c) nc = 0;
    else if (l) nc = lv;
    else if (e) begin
      if (m_cnt[k] != t) begin
        nc  = (m_cnt[k] + d) % MOD;
        tcn = !wr && (nc == t);
      end else if (wr) begin
        nc  = (m_cnt[k] + d) % MOD;
        tcn = 1;
      end
    end
    m_cnt[k] = nc;
    m_tc[k]  = tcn;
    ups       = m_ups[k];
    m_mm[k]   = ec ? 1'b0 : (m_mm[k] || ups || m_pend[k]);
    m_pend[k] = ups && ec;
    if (ec) m_err[k] = ups ? 1 : 0;
    else if (ups) m_err[k] = (m_err[k] + 1 > ERR_MAX) ? ERR_MAX : m_err[k] + 1;
    m_ups[k] = ups ? 1'b0 : i;
  endtask

  task automatic push_exp();
    q_w.push_back('{m_cnt[0], m_tc[0], m_mm[0], m_err[0]});
    q_s.push_back('{m_cnt[1], m_tc[1], m_mm[1], m_err[1]});
  endtask

  task automatic step(bit e, bit u, bit c, bit l, int lv, bit i, bit ec);
    @(negedge clk);
    nreset = 1; en = e; up = u; clr = c; load = l; load_val = W'(lv); inj = i; err_clr = ec;
    model_step(0, 1'b1, e, u, c, l, lv, i, ec);
    model_step(1, 1'b0, e, u, c, l, lv, i, ec);
    push_exp();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_cnt_w"}, cnt_w, 0);   chk({tag, "_out_w"}, cntout_w, 0);
    chk({tag, "_tc_w"}, tc_w, 0);     chk({tag, "_mm_w"}, mm_w, 0);
    chk({tag, "_err_w"}, err_w, 0);
    chk({tag, "_cnt_s"}, cnt_s, 0);   chk({tag, "_tc_s"}, tc_s, 0);
    chk({tag, "_mm_s"}, mm_s, 0);     chk({tag, "_err_s"}, err_s, 0);
  endtask

  // Reset asserted mid-cycle; outputs must clear before the next rising edge.
  task automatic do_reset();
    @(negedge clk);
    #1 nreset = 0;
    #1 chk_zero("async_rst");
    model_reset();
    push_exp();
  endtask

  // Monitor: one expectation per rising edge, sampled just after it.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q_w.size() > 0) begin
        x = q_w.pop_front();
        chk("wrap_cnt", cnt_w, x.cnt);
        chk("wrap_cntout", cntout_w, x.cnt >> 4);
        chk("wrap_tc", tc_w, x.tc);
        chk("wrap_mismatch", mm_w, x.mm);
        chk("wrap_err_cnt", err_w, x.err);
      end
      if (q_s.size() > 0) begin
        x = q_s.pop_front();
        chk("sat_cnt", cnt_s, x.cnt);
        chk("sat_cntout", cntout_s, x.cnt >> 4);
        chk("sat_tc", tc_s, x.tc);
        chk("sat_mismatch", mm_s, x.mm);
        chk("sat_err_cnt", err_s, x.err);
      end
    end
  end

  initial begin
    bit ru;
    int lv, sel;
    nreset = 1; en = 0; up = 1; clr = 0; load = 0; load_val = '0; inj = 0; err_clr = 0;
    model_reset();
    #2 nreset = 0;
    #1 chk_zero("init_rst");
    repeat (2) do_reset();

    // Free-running up count through a full wrap.
    repeat (258) step(1, 1, 0, 0, 0, 0, 0);
    // Load near the top, run into T, back off and return for a second pulse.
    step(0, 1, 0, 1, 250, 0, 0);
    repeat (8) step(1, 1, 0, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    repeat (5) step(1, 1, 0, 0, 0, 0, 0);
    // Down count through zero; load of T must not pulse.
    step(0, 0, 0, 1, 3, 0, 0);
    repeat (5) step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, MAXV, 0, 0);
    step(1, 1, 1, 1, 'h55, 0, 0);
    repeat (5) step(1, 1, 0, 0, 0, 0, 0);
    do_reset();

    // Single upset, then five spaced upsets to saturate the 2-bit counter.
    repeat (10) step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0);
    repeat (6) step(1, 1, 0, 0, 0, 0, 0);
    repeat (5) begin
      step(1, 1, 0, 0, 0, 1, 0);
      repeat (3) step(1, 1, 0, 0, 0, 0, 0);
    end
    step(1, 1, 0, 0, 0, 0, 1);
    repeat (2) step(1, 1, 0, 0, 0, 0, 0);
    // Injection together with err_clr while a mismatch is pending.
    step(1, 1, 0, 0, 0, 1, 0);
    repeat (3) step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 1);
    repeat (4) step(1, 1, 0, 0, 0, 0, 0);
    // Detection in the same cycle as err_clr, and injection on a resync cycle.
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 0, 1);
    repeat (3) step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    // Reset while a mismatch is flagged.
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    do_reset();

    // Randomised traffic, loads biased toward the terminal values.
    ru = 1;
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) ru = ~ru;
      sel = $urandom_range(0, 4);
      lv  = (sel == 0) ? 0 : (sel == 1) ? 1 : (sel == 2) ? MAXV - 1 :
            (sel == 3) ? MAXV : $urandom_range(0, MAXV);
      if ($urandom_range(0, 299) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, ru,
                $urandom_range(0, 39) == 0, $urandom_range(0, 24) == 0, lv,
                $urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q_w.size() + q_s.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cnt_mon.md
Name: cnt_mon

Overview:
- Parametrised successor to the fixed 28-bit free-running counter used as a DUT activity indicator on the daughter boards.
- Adds the following to the counter:
  - configurable width and output slice
  - enable, up/down, synchronous clear and load
  - wrap or saturate mode
  - terminal-count pulse
- Runs a duplicated shadow counter compared every cycle, so single-event upsets in the count state are detected, counted and flagged to the test controller.

Parameters:
- WIDTH, 28: counter width in bits (minimum 2).
- OUT_W, 4: number of MSBs presented on cntout (1 ≤ OUT_W ≤ WIDTH).
- ERR_W, 8: width of the upset event counter.
- WRAP, 1: 1 = wrap at terminal value; 0 = saturate at terminal value.

Ports:
- clk, input, 1: rising-edge clock.
- nreset, input, 1: asynchronous active-low reset.
- en, input, 1: count enable.
- up, input, 1: 1 = count up, 0 = count down.
- clr, input, 1: synchronous clear to zero.
- load, input, 1: synchronous load of load_val.
- load_val, input, WIDTH: value loaded when load = 1.
- inj, input, 1: test-only fault injection; flips bit 0 of the shadow copy.
- err_clr, input, 1: synchronous clear of mismatch and err_cnt.
- cntout, output, OUT_W: cnt[WIDTH-1 : WIDTH-OUT_W] of the primary counter.
- cnt_full, output, WIDTH: full primary count value.
- tc, output, 1: one-cycle terminal-count pulse.
- mismatch, output, 1: sticky upset flag.
- err_cnt, output, ERR_W: saturating count of detected mismatches.

Behaviour:
- Reset (nreset low, asynchronous): primary A = 0, shadow B = 0, tc = 0, mismatch = 0, err_cnt = 0.
  - All outputs are 0 while reset is held.
  - Release is synchronised by the upstream reset bridge; no in-block synchroniser.
- Update priority per clock, applied identically to A and B:
  - clr: next = 0.
  - else load: next = load_val.
  - else en: advance.
  - else hold.
- Terminal value T: up = 1 gives all-ones; up = 0 gives zero.
- Advance rule:
  - Count ≠ T: next = count ± 1, modulo 2^WIDTH.
  - Count == T, WRAP = 1: next = count ± 1, modulo 2^WIDTH (all-ones → 0 going up; 0 → all-ones going down).
  - Count == T, WRAP = 0: hold at T.
- tc (registered):
  - High for exactly one cycle, the cycle after A enters T by advance, or wraps out of T (WRAP = 1 only).
  - Not asserted by clr or load, even if the loaded value is T.
  - WRAP = 0: pulses once on reaching T; no repeat while held.
  - Changing direction at T then advancing away and back produces a new pulse.
- Latency:
  - cntout and cnt_full are registered with no extra pipeline; they reflect A directly, updating the cycle after the control inputs.
- Compare:
  - Each cycle, registered check of (A != B) as a one-bit stage; detection latency is 1 cycle after the divergence appears.
- On detected mismatch:
  - mismatch sets and stays set.
  - err_cnt increments, saturating at 2^ERR_W − 1.
  - B is overwritten with next(A) in the same update, so a single upset counts exactly once.
- inj:
  - B's next value is XORed with 1 in bit 0 on that cycle.
  - If inj coincides with a resync cycle, the resync wins and the injection is dropped.
- err_clr:
  - Clears mismatch and err_cnt.
  - If a new mismatch is detected in the same cycle, err_clr wins the flag and err_cnt restarts at 1; the flag is then reasserted (set has precedence in the count, clear in the flag).
- Simultaneous clr + load: clr wins.
- clr/load while en: en is ignored for that cycle.
- Reset mid-count or mid-mismatch: everything returns to reset values immediately; no memory of upsets survives reset.

Decomposition:
- Shared package cnt_mon_pkg:
  - localparam helpers: terminal value function term(up, WIDTH); err saturation constant.
  - No typedefs required.
- One sub-module is natural: cnt_core, the WIDTH-bit up/down/load/clear counter with wrap/saturate and tc.
  - Instantiated twice (A, B); B's next-value path carries the inj/resync mux.
- The compare and error logic stays in the top.

Test Plan:
1. WIDTH = 8, en = 1, up = 1 from reset → cnt_full 0, 1, 2, …, 255, 0; tc high only in the cycle showing 0 after 255; cntout (OUT_W = 4) = 0xF for counts 240–255.
2. WIDTH = 8, WRAP = 0, load_val = 250, load, then en up → 251…255 then holds 255; tc one pulse at 255 only; down then back up to 255 → second pulse.
3. up = 0 from 3 → 2, 1, 0, 255 (WRAP = 1), tc once on wrap; clr and load asserted together with load_val = 0x55 → 0; mid-count nreset low → all outputs 0 asynchronously, before the next clk edge.
4. Single inj pulse during counting → mismatch = 1 one cycle later, err_cnt = 1, A unaffected, B equals A on the following cycle; no further increments.
5. ERR_W = 2, five inj pulses spaced 4 cycles apart → err_cnt 1, 2, 3, 3, 3; err_clr → mismatch = 0, err_cnt = 0.
6. inj in the same cycle as err_clr with a pending mismatch → err_cnt = 1 and mismatch = 1 afterwards, per the stated precedence.
